// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared register-file constants for the scoreboard.
package reg_scoreboard_pkg;
    localparam int ADDR_WID = 4;
    localparam int DATA_WID = 64;
    localparam int SB_CNT_WID = 2;
    localparam logic [ADDR_WID-1:0] RNONE = 4'hF;
endpackage

// File: rtl/reg_cnt_slot.sv
// reg_cnt_slot: per-register saturating pending-write counter with clamp-to-zero underflow.
module reg_cnt_slot import reg_scoreboard_pkg::*; #(
    parameter int CNT_WID = SB_CNT_WID
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         inc,
    input  logic [1:0]         dec,
    input  logic               clr,
    output logic               busy,
    output logic [CNT_WID-1:0] room,
    output logic               under
);
    logic [CNT_WID-1:0] cnt, nxt;
    logic [CNT_WID+1:0] up, diff;

    always_comb begin
        up    = {2'b0, cnt} + {{CNT_WID{1'b0}}, inc};
        diff  = up - {{CNT_WID{1'b0}}, dec};
        under = !clr && ({{CNT_WID{1'b0}}, dec} > up);
        nxt   = (clr || under) ? '0 : (|diff[CNT_WID+1:CNT_WID]) ? '1 : diff[CNT_WID-1:0];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= nxt;

    assign busy = cnt != '0;
    assign room = ~cnt;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: in-flight register write tracking and decode issue gating.
// Optional SCOREBOARD_STATS_EN adds a saturating stall_cnt output.
module reg_scoreboard import reg_scoreboard_pkg::*; #(
    parameter int ADDR_WID = reg_scoreboard_pkg::ADDR_WID,
    parameter int NREG     = 2**ADDR_WID,
    parameter int CNT_WID  = SB_CNT_WID
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [ADDR_WID-1:0] issue_srcA,
    input  logic [ADDR_WID-1:0] issue_srcB,
    input  logic [ADDR_WID-1:0] issue_dstE,
    input  logic [ADDR_WID-1:0] issue_dstM,
    input  logic                wb_validE,
    input  logic [ADDR_WID-1:0] wb_dstE,
    input  logic                wb_validM,
    input  logic [ADDR_WID-1:0] wb_dstM,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec,
`ifdef SCOREBOARD_STATS_EN
    output logic [15:0]         stall_cnt,
`endif
    output logic                err
);
    localparam logic [ADDR_WID-1:0] NONE = ADDR_WID'(RNONE);

    logic [NREG-2:0] busy, under, ovf;
    logic            hazard, accept;

    // The last address is RNONE: no slot, so its busy bit is tied low.
    for (genvar i = 0; i < NREG - 1; i++) begin : g_slot
        localparam logic [ADDR_WID-1:0] R = ADDR_WID'(i);
        logic [1:0]         inc, dec;
        logic [CNT_WID-1:0] room;
        assign inc    = 2'(issue_dstE == R) + 2'(issue_dstM == R);
        assign dec    = 2'(wb_validE && wb_dstE == R) + 2'(wb_validM && wb_dstM == R);
        assign ovf[i] = int'(inc) > int'(room);
        reg_cnt_slot #(.CNT_WID(CNT_WID)) u_slot (
            .clk   (CLK),
            .rst_n (RST_N),
            .inc   (accept ? inc : 2'd0),
            .dec   (dec),
            .clr   (flush),
            .busy  (busy[i]),
            .room  (room),
            .under (under[i])
        );
    end

    assign busy_vec    = {1'b0, busy};
    assign hazard      = (issue_srcA != NONE && busy_vec[issue_srcA]) ||
                         (issue_srcB != NONE && busy_vec[issue_srcB]);
    assign issue_ready = !flush && !hazard && !(|ovf);
    assign accept      = issue_valid && issue_ready;

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) err <= 1'b0;
        else if (|under) err <= 1'b1;

`ifdef SCOREBOARD_STATS_EN
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) stall_cnt <= '0;
        else if (flush) stall_cnt <= '0;
        else if (issue_valid && !issue_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vectors with hand-computed expectations for reg_scoreboard.
module tb_reg_scoreboard;
    localparam logic [3:0] RN = 4'hF;

    logic        CLK = 1'b0, RST_N;
    logic        issue_valid, issue_ready, wb_validE, wb_validM, flush, err;
    logic [3:0]  issue_srcA, issue_srcB, issue_dstE, issue_dstM, wb_dstE, wb_dstM;
    logic [15:0] busy_vec;
`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_cnt;
`endif
    int n_chk = 0, n_fail = 0;

    always #5 CLK = ~CLK;

    reg_scoreboard dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_srcA  (issue_srcA),
        .issue_srcB  (issue_srcB),
        .issue_dstE  (issue_dstE),
        .issue_dstM  (issue_dstM),
        .wb_validE   (wb_validE),
        .wb_dstE     (wb_dstE),
        .wb_validM   (wb_validM),
        .wb_dstM     (wb_dstM),
        .flush       (flush),
        .busy_vec    (busy_vec),
`ifdef SCOREBOARD_STATS_EN
        .stall_cnt   (stall_cnt),
`endif
        .err         (err)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle;
        issue_valid = 1'b0;
        issue_srcA = RN; issue_srcB = RN; issue_dstE = RN; issue_dstM = RN;
        wb_validE = 1'b0; wb_dstE = RN; wb_validM = 1'b0; wb_dstM = RN;
        flush = 1'b0;
    endtask

    task automatic iss(input logic [3:0] a, input logic [3:0] b, input logic [3:0] e, input logic [3:0] m);
        issue_valid = 1'b1;
        issue_srcA = a; issue_srcB = b; issue_dstE = e; issue_dstM = m;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle;
        RST_N = 1'b0;
        repeat (2) tick;
        check("rst_busy", busy_vec, 16'h0000);
        check("rst_err", 16'(err), 16'd0);
        check("rst_ready", 16'(issue_ready), 16'd1);
        RST_N = 1'b1;
        tick;
        // basic issue then hazard on its destination
        iss(4'd1, 4'd2, 4'd3, RN); #1;
        check("issue_ready", 16'(issue_ready), 16'd1);
        tick; idle; #1;
        check("busy3", busy_vec, 16'h0008);
        iss(4'd3, RN, RN, RN); wb_validE = 1'b1; wb_dstE = 4'd3; #1;
        check("haz_a_same_cycle_wb", 16'(issue_ready), 16'd0);
        tick; wb_validE = 1'b0; #1;
        check("haz_a_release", 16'(issue_ready), 16'd1);
        check("wb_clear", busy_vec, 16'h0000);
        tick;
        // double destination and overflow
        iss(RN, RN, 4'd5, 4'd5); #1;
        check("dual_dst_ready", 16'(issue_ready), 16'd1);
        tick; #1;
        check("busy5", busy_vec, 16'h0020);
        check("ovf_stall", 16'(issue_ready), 16'd0);
        wb_validM = 1'b1; wb_dstM = 4'd5; #1;
        check("ovf_wb_same_cycle", 16'(issue_ready), 16'd0);
        tick; wb_validM = 1'b0; #1;
        check("ovf_release", 16'(issue_ready), 16'd1);
        tick;
        iss(RN, RN, 4'd5, RN); #1;
        check("ovf_single_at_max", 16'(issue_ready), 16'd0);
        idle; wb_validE = 1'b1; wb_dstE = 4'd5; wb_validM = 1'b1; wb_dstM = 4'd5;
        tick; wb_validM = 1'b0;
        tick; idle; #1;
        check("drain5", busy_vec, 16'h0000);
        // issue and writeback to the same register in one cycle
        iss(RN, RN, 4'd7, RN);
        tick; wb_validE = 1'b1; wb_dstE = 4'd7; #1;
        check("net7_ready", 16'(issue_ready), 16'd1);
        tick; idle; #1;
        check("net7_busy", busy_vec, 16'h0080);
        wb_validE = 1'b1; wb_dstE = 4'd7;
        tick; idle; #1;
        check("net7_drain", busy_vec, 16'h0000);
        check("net7_err", 16'(err), 16'd0);
        // writeback to RNONE is ignored, then an underflow
        wb_validE = 1'b1; wb_dstE = RN;
        tick; idle; #1;
        check("wb_rnone_err", 16'(err), 16'd0);
        wb_validM = 1'b1; wb_dstM = 4'd9;
        tick; idle; #1;
        check("underflow_err", 16'(err), 16'd1);
        check("underflow_clamp", busy_vec, 16'h0000);
        tick;
        check("err_sticky", 16'(err), 16'd1);
        // srcB hazard, then flush beats issue and writeback
        iss(RN, RN, 4'd2, 4'd4);
        tick; iss(RN, 4'd4, RN, RN); #1;
        check("busy_2_4", busy_vec, 16'h0014);
        check("haz_b", 16'(issue_ready), 16'd0);
        iss(RN, RN, 4'd6, RN); flush = 1'b1; wb_validE = 1'b1; wb_dstE = 4'd2; #1;
        check("flush_ready", 16'(issue_ready), 16'd0);
        tick; idle; #1;
        check("flush_busy", busy_vec, 16'h0000);
        check("flush_err", 16'(err), 16'd1);
`ifdef SCOREBOARD_STATS_EN
        check("flush_stall_cnt", stall_cnt, 16'd0);
        iss(RN, RN, 4'd1, RN);
        tick; iss(4'd1, RN, RN, RN);
        tick; idle; #1;
        check("stall_cnt_one", stall_cnt, 16'd1);
        wb_validE = 1'b1; wb_dstE = 4'd1;
        tick; idle;
`endif
        // asynchronous reset mid-run
        iss(RN, RN, 4'd3, 4'd8);
        tick; idle; #1;
        check("pre_rst_busy", busy_vec, 16'h0108);
        RST_N = 1'b0; #1;
        check("async_busy", busy_vec, 16'h0000);
        check("async_ready", 16'(issue_ready), 16'd1);
        check("async_err", 16'(err), 16'd0);
        #1 RST_N = 1'b1;
        tick;
        check("post_rst_busy", busy_vec, 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Tracks in-flight register writes for the register file and gates instruction issue in the decode stage. An issue is stalled while either source register has an outstanding write from the E or M stage. The block counts issues against register destinations and counts writebacks from the E and M write ports. It sits between decode, which issues, and the register file write ports, which write back.

## Interface
Parameters:
- `ADDR_WID`, default 4: register address width (`ADDR_WID` from head.v).
- `NREG`, default 16: number of registers, 2**ADDR_WID.
- `CNT_WID`, default 2: width of each per-register pending counter; MAX = 2**CNT_WID-1.

Ports (clock and reset first):
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: decode presents an instruction.
- `issue_ready` out 1: issue accepted this cycle when `issue_valid & issue_ready`.
- `issue_srcA`, `issue_srcB` in ADDR_WID: registers read by the instruction; `RNONE` (4'hF) means no read.
- `issue_dstE`, `issue_dstM` in ADDR_WID: registers the instruction will write; `RNONE` means no write.
- `wb_validE`, `wb_dstE` in 1 / ADDR_WID: E-port writeback completes this cycle.
- `wb_validM`, `wb_dstM` in 1 / ADDR_WID: M-port writeback completes this cycle.
- `flush` in 1: discard all pending state.
- `busy_vec` out NREG: bit r = (cnt[r] != 0).
- `err` out 1: sticky flag, set on counter underflow.

## Operation
- State: cnt[r] for r in 0..NREG-2. Register `RNONE` has no counter and is never busy.
- Source hazard: src != RNONE and cnt[src] != 0, checked for srcA and srcB.
- Destination increments: incE = (dstE != RNONE), incM = (dstM != RNONE). A register named by both dstE and dstM gets +2.
- Overflow: cnt[d] + inc[d] > MAX for any destination d.
- `issue_ready` = !flush & !hazard & !overflow. It is combinational and uses only current-cycle state.
- On accept: cnt[dst] increases by its increment.
- Writeback: each valid wb with dst != RNONE decrements cnt[dst] by 1. Two writebacks to the same register decrement by 2.
- A writeback with wb_valid set and dst = RNONE is ignored.
- Issue and writeback to the same register in the same cycle: net update, cnt + inc - dec.
- Underflow: a decrement larger than cnt clamps cnt to 0 and sets `err`. `err` clears only on reset.
- Flush: all cnt = 0 next edge. The flush has priority over a simultaneous issue or writeback. `issue_ready` = 0 during the flush cycle.

## Timing
- Reset values: all cnt = 0, `busy_vec` = 0, `err` = 0. `issue_ready` = 1 after reset when `flush` = 0.
- Writeback at cycle N clears the hazard from cycle N+1. There is no same-cycle release.
- An issue at cycle N makes its destination busy from cycle N+1; `busy_vec` is registered-state-derived.
- Reset asserted mid-operation clears everything immediately; no pending writes survive.

## Configuration
- Macro `SCOREBOARD_STATS_EN`.
- Defined: adds output `stall_cnt` [15:0]. It increments on each cycle with `issue_valid & !issue_ready`, saturates at 16'hFFFF, resets to 0 and is cleared by `flush`.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Constants in head.v: `ADDR_WID`, `DATA_WID`, `RNONE` = 4'hF, and `SB_CNT_WID`.
- Sub-module `reg_cnt_slot`: one per register, holding a saturating up/down counter with inc[1:0], dec[1:0] and clr. It outputs busy, full-check headroom and underflow.
- Top level: decode of issue and writeback addresses into per-slot inc/dec, hazard muxing, and `err`/stats.

## Test plan
- After reset, issue srcA=1, srcB=2, dstE=3, dstM=RNONE -> `issue_ready`=1; next cycle `busy_vec`=16'h0008.
- Next instruction has srcA=3 -> `issue_ready`=0. wb_validE with dstE=3 -> ready=1 one cycle later, `busy_vec`=0.
- Issue dstE=dstM=5 three times (CNT_WID=2) -> first accepted with cnt=2; the second stalls with overflow. M writeback to 5 -> cnt=1, second accepted.
- Issue to 7 while wbE to 7 is in the same cycle with cnt[7]=1 -> cnt[7] stays 1, `busy_vec`[7]=1.
- wbM dstM=9 with cnt[9]=0 -> `err`=1 and it stays set. `flush` -> `busy_vec`=0, `err` still 1, and `stall_cnt`=0 when stats are enabled.
- Assert `RST_N`=0 asynchronously mid-run with several registers busy -> `busy_vec`=0 before the next edge and `issue_ready`=1.
